// File: rtl/clk_divider_prog.sv
// Programmable clock divider.
//
// Counts qualified advance edges (i_clk_en & i_count_valid) modulo an active ratio R and derives
// a registered divided clock that is low for ceil(R/2) counts and high for floor(R/2) counts.
// A new ratio may be requested at any time; it is held as pending and applied only when the
// counter wraps, so a period is never cut short or stretched by a ratio change.
//
// Ports:
//   clk            rising-edge system clock (the only clock)
//   resetn         asynchronous active-low reset
//   i_clk_en       synchronous clock enable
//   i_count_valid  counter advance qualifier
//   i_div_load     one-cycle request to load i_div_ratio
//   i_div_ratio    requested ratio, sampled when i_div_load=1
//   o_div_load_ack one-cycle pulse after a pending ratio becomes active
//   o_div_err      one-cycle pulse after a load with ratio < 2 is rejected
//   o_count        current count, 0..R-1
//   o_count_end    high while o_count == R-1
//   o_div_tick     one-cycle pulse after the counter wraps to 0
//   o_div_clk      registered divided clock
module clk_divider_prog #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEFAULT_RATIO = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clk_en,
  input  logic             i_count_valid,
  input  logic             i_div_load,
  input  logic [WIDTH-1:0] i_div_ratio,
  output logic             o_div_load_ack,
  output logic             o_div_err,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end,
  output logic             o_div_tick,
  output logic             o_div_clk
);

  localparam logic [WIDTH-1:0] RstRatio = WIDTH'(DEFAULT_RATIO);

  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] pend_ratio_q, pend_ratio_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             div_clk_q, div_clk_d;
  logic             tick_q;
  logic             ack_q, ack_d;
  logic             err_q;

  logic advance, at_end, wrap, load_bad, load_ok;

  always_comb begin
    advance  = i_clk_en & i_count_valid;
    // R >= 2 always holds, so R-1 never underflows.
    at_end   = (count_q == (ratio_q - WIDTH'(1)));
    wrap     = advance & at_end;
    load_bad = i_div_load & (i_div_ratio < WIDTH'(2));
    load_ok  = i_div_load & ~load_bad;

    ratio_d      = ratio_q;
    pend_ratio_d = pend_ratio_q;
    pend_d       = pend_q;
    ack_d        = 1'b0;
    count_d      = count_q;

    // Apply before capturing a new load so that a load on the wrap edge becomes the next pending.
    if (wrap && pend_q) begin
      ratio_d = pend_ratio_q;
      pend_d  = 1'b0;
      ack_d   = 1'b1;
    end
    if (load_ok) begin
      pend_ratio_d = i_div_ratio;
      pend_d       = 1'b1;
    end

    if (advance) begin
      count_d = wrap ? '0 : count_q + WIDTH'(1);
    end

    // Threshold uses the ratio in force next cycle; when not advancing this reproduces div_clk_q.
    div_clk_d = (count_d >= (ratio_d - (ratio_d >> 1)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ratio_q      <= RstRatio;
      pend_ratio_q <= RstRatio;
      pend_q       <= 1'b0;
      count_q      <= '0;
      div_clk_q    <= 1'b0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ratio_q      <= ratio_d;
      pend_ratio_q <= pend_ratio_d;
      pend_q       <= pend_d;
      count_q      <= count_d;
      div_clk_q    <= div_clk_d;
      tick_q       <= wrap;
      ack_q        <= ack_d;
      err_q        <= load_bad;
    end
  end

  assign o_count        = count_q;
  assign o_count_end    = at_end;
  assign o_div_tick     = tick_q;
  assign o_div_clk      = div_clk_q;
  assign o_div_load_ack = ack_q;
  assign o_div_err      = err_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
module tb_clk_divider_prog;

  logic       clk = 1'b0;
  logic       resetn;
  logic       i_clk_en;
  logic       i_count_valid;
  logic       i_div_load;
  logic [7:0] i_div_ratio;
  logic       o_div_load_ack;
  logic       o_div_err;
  logic [7:0] o_count;
  logic       o_count_end;
  logic       o_div_tick;
  logic       o_div_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected count and active ratio, updated by the directed steps below.
  int exp_cnt = 0;
  int exp_r   = 8;

  clk_divider_prog #(
    .WIDTH        (8),
    .DEFAULT_RATIO(8)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_clk_en      (i_clk_en),
    .i_count_valid (i_count_valid),
    .i_div_load    (i_div_load),
    .i_div_ratio   (i_div_ratio),
    .o_div_load_ack(o_div_load_ack),
    .o_div_err     (o_div_err),
    .o_count       (o_count),
    .o_count_end   (o_count_end),
    .o_div_tick    (o_div_tick),
    .o_div_clk     (o_div_clk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int tick, input int ack, input int err);
    chk({tag, " count"}, int'(o_count), exp_cnt);
    chk({tag, " div_clk"}, int'(o_div_clk), int'(exp_cnt >= exp_r - exp_r / 2));
    chk({tag, " count_end"}, int'(o_count_end), int'(exp_cnt == exp_r - 1));
    chk({tag, " tick"}, int'(o_div_tick), tick);
    chk({tag, " ack"}, int'(o_div_load_ack), ack);
    chk({tag, " err"}, int'(o_div_err), err);
  endtask

  // One clock edge with the given inputs. new_r != 0 means an ack is expected on this edge and
  // the given ratio becomes active from the following cycle.
  task automatic step(input string tag, input logic en, input logic vld, input logic ld,
                      input int ratio, input int new_r);
    int wrapped;
    i_clk_en      = en;
    i_count_valid = vld;
    i_div_load    = ld;
    i_div_ratio   = 8'(ratio);
    @(posedge clk);
    #1;
    wrapped = 0;
    if (en && vld) begin
      wrapped = int'(exp_cnt == exp_r - 1);
      exp_cnt = (wrapped != 0) ? 0 : exp_cnt + 1;
    end
    if (new_r != 0) exp_r = new_r;
    chk_all(tag, wrapped, int'(new_r != 0), int'(ld && ratio < 2));
    i_div_load = 1'b0;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b0;
    i_clk_en      = 1'b1;
    i_count_valid = 1'b1;
    i_div_load    = 1'b0;
    i_div_ratio   = 8'd0;
    #12;
    chk_all("reset", 0, 0, 0);
    resetn = 1'b1;

    // Defaults: 32 cycles of R=8.
    run("default", 32);

    // Rejected loads: ratio 1 then ratio 0; R stays 8, no ack at next wrap.
    step("load1", 1'b1, 1'b1, 1'b1, 1, 0);
    run("after_load1", 1);
    step("load0", 1'b1, 1'b1, 1'b1, 0, 0);
    run("after_load0", 5);
    chk("r_still_8", exp_cnt, 0);

    // Hold with i_count_valid=0 at count 5, then with i_clk_en=0.
    run("to5_a", 5);
    for (int i = 0; i < 3; i++) step("hold_vld", 1'b1, 1'b0, 1'b0, 0, 0);
    run("finish_a", 3);
    run("to5_b", 5);
    for (int i = 0; i < 3; i++) step("hold_en", 1'b0, 1'b1, 1'b0, 0, 0);
    run("finish_b", 3);

    // Load 5 at count 2: current period completes at 8, then periods of 5.
    run("to2", 2);
    step("load5", 1'b1, 1'b1, 1'b1, 5, 0);
    run("old_period", 4);
    step("apply5", 1'b1, 1'b1, 1'b0, 0, 5);
    run("r5", 10);

    // Load 6 then 3 (last wins); 7 loaded on the wrap edge applies at the following wrap.
    step("load6", 1'b1, 1'b1, 1'b1, 6, 0);
    step("load3", 1'b1, 1'b1, 1'b1, 3, 0);
    run("to4", 2);
    step("apply3_load7", 1'b1, 1'b1, 1'b1, 7, 3);
    run("r3", 2);
    step("apply7", 1'b1, 1'b1, 1'b0, 0, 7);

    // Reset at count 6 with a load pending.
    run("to5_c", 5);
    step("load3_pend", 1'b1, 1'b1, 1'b1, 3, 0);
    chk("at6", int'(o_count), 6);
    #2;
    resetn = 1'b0;
    #1;
    exp_cnt = 0;
    exp_r   = 8;
    chk_all("async_reset", 0, 0, 0);
    #2;
    resetn = 1'b1;
    run("post_reset", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
